// File: rtl/syscall_unit.sv
// Execute-stage system-call handler: stalls the pipeline while it services print_string,
// print_int, print_char and exit, and sends bytes to the console over a valid/ready stream.
module syscall_unit #(
    parameter int unsigned MAX_STR_LEN = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        syscall_req,
    input  logic [31:0] sys_call_reg,
    input  logic [31:0] std_out_address,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        halted,
    output logic        err_unsupported
);

    localparam int unsigned CW = $clog2(MAX_STR_LEN + 1);

    typedef enum logic [2:0] {IDLE, STR_REQ, STR_CHK, INT_DIGIT, EMIT, DONE, HALT} state_t;
    typedef enum logic [1:0] {SVC_STR, SVC_INT, SVC_CHR} svc_t;

    state_t        state_q;
    svc_t          svc_q;
    logic [CW-1:0] count_q;
    logic [31:0]   mag_q;
    logic [3:0]    pow_q;
    logic [3:0]    digit_q;
    logic          started_q;
    logic [31:0]   mem_addr_q;
    logic          mem_rd_q;
    logic [7:0]    char_out_q;
    logic          char_valid_q;
    logic          halted_q;
    logic          err_q;

    function automatic logic [31:0] pow10(input logic [3:0] p);
        case (p)
            4'd9:    pow10 = 32'd1000000000;
            4'd8:    pow10 = 32'd100000000;
            4'd7:    pow10 = 32'd10000000;
            4'd6:    pow10 = 32'd1000000;
            4'd5:    pow10 = 32'd100000;
            4'd4:    pow10 = 32'd10000;
            4'd3:    pow10 = 32'd1000;
            4'd2:    pow10 = 32'd100;
            4'd1:    pow10 = 32'd10;
            default: pow10 = 32'd1;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            svc_q        <= SVC_STR;
            count_q      <= '0;
            mag_q        <= '0;
            pow_q        <= '0;
            digit_q      <= '0;
            started_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            char_out_q   <= '0;
            char_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            mem_rd_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: if (syscall_req) begin
                    case (sys_call_reg)
                        32'd4: begin
                            svc_q      <= SVC_STR;
                            mem_addr_q <= std_out_address;
                            count_q    <= '0;
                            mem_rd_q   <= 1'b1;
                            state_q    <= STR_REQ;
                        end
                        32'd1: begin
                            svc_q     <= SVC_INT;
                            pow_q     <= 4'd9;
                            digit_q   <= '0;
                            started_q <= 1'b0;
                            if (std_out_address[31]) begin
                                mag_q        <= -std_out_address;
                                char_out_q   <= 8'h2D;
                                char_valid_q <= 1'b1;
                                state_q      <= EMIT;
                            end else begin
                                mag_q   <= std_out_address;
                                state_q <= INT_DIGIT;
                            end
                        end
                        32'd11: begin
                            svc_q        <= SVC_CHR;
                            char_out_q   <= std_out_address[7:0];
                            char_valid_q <= 1'b1;
                            state_q      <= EMIT;
                        end
                        32'd10: begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end
                        default: begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end
                    endcase
                end
                STR_REQ: state_q <= STR_CHK;
                STR_CHK: begin
                    if (mem_rdata == '0 || count_q == CW'(MAX_STR_LEN)) begin
                        state_q <= DONE;
                    end else begin
                        char_out_q   <= mem_rdata;
                        char_valid_q <= 1'b1;
                        state_q      <= EMIT;
                    end
                end
                // Repeated subtraction builds one decimal digit per power; leading zeros are skipped.
                INT_DIGIT: begin
                    if (mag_q >= pow10(pow_q)) begin
                        mag_q   <= mag_q - pow10(pow_q);
                        digit_q <= digit_q + 4'd1;
                    end else if (digit_q != '0 || started_q || pow_q == '0) begin
                        char_out_q   <= 8'h30 + {4'h0, digit_q};
                        char_valid_q <= 1'b1;
                        started_q    <= 1'b1;
                        state_q      <= EMIT;
                    end else begin
                        pow_q <= pow_q - 4'd1;
                    end
                end
                EMIT: if (char_ready) begin
                    char_valid_q <= 1'b0;
                    case (svc_q)
                        SVC_STR: begin
                            mem_addr_q <= mem_addr_q + 32'd1;
                            count_q    <= count_q + CW'(1);
                            mem_rd_q   <= 1'b1;
                            state_q    <= STR_REQ;
                        end
                        // A transfer with no digit started yet was the '-' sign.
                        SVC_INT: begin
                            if (!started_q) begin
                                state_q <= INT_DIGIT;
                            end else if (pow_q == '0) begin
                                state_q <= DONE;
                            end else begin
                                pow_q   <= pow_q - 4'd1;
                                digit_q <= '0;
                                state_q <= INT_DIGIT;
                            end
                        end
                        default: state_q <= DONE;
                    endcase
                end
                DONE:    state_q <= IDLE;
                HALT:    state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall           = (state_q == IDLE) ? syscall_req : (state_q != DONE);
    assign mem_addr        = mem_addr_q;
    assign mem_rd          = mem_rd_q;
    assign char_out        = char_out_q;
    assign char_valid      = char_valid_q;
    assign halted          = halted_q;
    assign err_unsupported = err_q;

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: byte-addressed memory model, console sink, and
// hand-computed expected output strings and cycle counts.
module tb_syscall_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        syscall_req = 1'b0;
    logic [31:0] sys_call_reg = '0;
    logic [31:0] std_out_address = '0;
    logic        stall;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready = 1'b1;
    logic        halted;
    logic        err_unsupported;

    int passed = 0;
    int total  = 0;

    logic [7:0]  rxq[$];
    logic [31:0] addrq[$];

    always #5 clk = ~clk;

    syscall_unit #(.MAX_STR_LEN(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .syscall_req     (syscall_req),
        .sys_call_reg    (sys_call_reg),
        .std_out_address (std_out_address),
        .stall           (stall),
        .mem_addr        (mem_addr),
        .mem_rd          (mem_rd),
        .mem_rdata       (mem_rdata),
        .char_out        (char_out),
        .char_valid      (char_valid),
        .char_ready      (char_ready),
        .halted          (halted),
        .err_unsupported (err_unsupported)
    );

    // "Hi\0" at 0x100, empty string at 0x200, everything else non-NUL and address-dependent.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h100: mem_byte = 8'h48;
            32'h101: mem_byte = 8'h69;
            32'h102: mem_byte = 8'h00;
            32'h200: mem_byte = 8'h00;
            default: mem_byte = 8'h61 + {6'd0, a[1:0]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= mem_byte(mem_addr);
            addrq.push_back(mem_addr);
        end
        if (!reset && char_valid && char_ready) rxq.push_back(char_out);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Issues one call and returns at the DONE cycle (stall low), or after the cycle budget.
    task automatic run_call(input logic [31:0] code, input logic [31:0] arg, input logic hold,
                            output int cyc, output logic [127:0] acc, output int n);
        int rx0;
        @(negedge clk);
        rx0 = rxq.size();
        syscall_req = 1'b1;
        sys_call_reg = code;
        std_out_address = arg;
        #1;
        cyc = 0;
        while (stall && cyc < 1000) begin
            cyc++;
            @(negedge clk);
            if (!hold) syscall_req = 1'b0;
        end
        syscall_req = 1'b0;
        check("call_timeout", 128'(cyc < 1000), 128'(1));
        acc = '0;
        n = rxq.size() - rx0;
        for (int i = rx0; i < rxq.size(); i++) acc = {acc[119:0], rxq[i]};
    endtask

    initial begin
        int cyc;
        int n;
        int aq0;
        int rxs;
        logic [127:0] acc;

        repeat (2) tick();
        check("rst_stall", 128'(stall), 128'(0));
        check("rst_mem_rd", 128'(mem_rd), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        check("rst_char_out", 128'(char_out), 128'(0));
        check("rst_char_valid", 128'(char_valid), 128'(0));
        check("rst_halted", 128'(halted), 128'(0));
        check("rst_err", 128'(err_unsupported), 128'(0));
        reset = 1'b0;

        aq0 = addrq.size();
        run_call(32'd4, 32'h100, 1'b0, cyc, acc, n);
        check("hi_count", 128'(n), 128'(2));
        check("hi_bytes", acc, "Hi");
        check("hi_cycles", 128'(cyc), 128'(9));
        check("hi_stall_done", 128'(stall), 128'(0));
        check("hi_reads", 128'(addrq.size() - aq0), 128'(3));
        check("hi_addrs", {32'h0, addrq[aq0], addrq[aq0+1], addrq[aq0+2]},
              {32'h0, 32'h100, 32'h101, 32'h102});

        run_call(32'd4, 32'h200, 1'b0, cyc, acc, n);
        check("empty_count", 128'(n), 128'(0));
        check("empty_cycles", 128'(cyc), 128'(3));

        run_call(32'd1, 32'd0, 1'b0, cyc, acc, n);
        check("int0_count", 128'(n), 128'(1));
        check("int0_str", acc, "0");
        run_call(32'd1, 32'd7, 1'b0, cyc, acc, n);
        check("int7_str", acc, "7");
        run_call(32'd1, 32'd100, 1'b0, cyc, acc, n);
        check("int100_str", acc, "100");
        run_call(32'd1, 32'hFFFF_FECF, 1'b0, cyc, acc, n);
        check("intm305_count", 128'(n), 128'(4));
        check("intm305_str", acc, "-305");
        run_call(32'd1, 32'h8000_0000, 1'b0, cyc, acc, n);
        check("intmin_count", 128'(n), 128'(11));
        check("intmin_str", acc, "-2147483648");

        // print_char with console back-pressure
        char_ready = 1'b0;
        rxs = rxq.size();
        tick();
        syscall_req = 1'b1;
        sys_call_reg = 32'd11;
        std_out_address = 32'h41;
        tick();
        syscall_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("chr_hold", {stall, char_valid, char_out}, {1'b1, 1'b1, 8'h41});
            tick();
        end
        char_ready = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (stall && cyc < 100);
        check("chr_bp_timeout", 128'(cyc < 100), 128'(1));
        check("chr_bp_count", 128'(rxq.size() - rxs), 128'(1));
        check("chr_bp_byte", 128'(rxq[rxs]), 128'(8'h41));

        run_call(32'd11, 32'h42, 1'b0, cyc, acc, n);
        check("chr_cycles", 128'(cyc), 128'(2));
        check("chr_str", acc, "B");

        run_call(32'd11, 32'h43, 1'b1, cyc, acc, n);
        rxs = rxq.size();
        repeat (3) tick();
        check("hold_once", 128'(n), 128'(1));
        check("hold_no_retrigger", 128'(rxq.size() - rxs), 128'(0));

        aq0 = addrq.size();
        run_call(32'd4, 32'hFFFF_FFFE, 1'b0, cyc, acc, n);
        check("wrap_count", 128'(n), 128'(4));
        check("wrap_bytes", acc, 128'h6364_6162);
        check("wrap_reads", 128'(addrq.size() - aq0), 128'(5));
        check("wrap_addrs", {32'h0, addrq[aq0+1], addrq[aq0+2], addrq[aq0+4]},
              {32'h0, 32'hFFFF_FFFF, 32'h0, 32'h2});

        run_call(32'd99, 32'd0, 1'b0, cyc, acc, n);
        check("unsup_err_hi", 128'(err_unsupported), 128'(1));
        check("unsup_no_bytes", 128'(n), 128'(0));
        tick();
        check("unsup_err_lo", 128'(err_unsupported), 128'(0));

        // reset while a string byte is waiting on the console
        char_ready = 1'b0;
        rxs = rxq.size();
        tick();
        syscall_req = 1'b1;
        sys_call_reg = 32'd4;
        std_out_address = 32'h100;
        tick();
        syscall_req = 1'b0;
        repeat (2) tick();
        check("rststr_valid_pre", 128'(char_valid), 128'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rststr_state", {char_valid, stall, mem_rd, mem_addr}, '0);
        char_ready = 1'b1;
        tick();
        check("rststr_no_xfer", 128'(rxq.size() - rxs), 128'(0));
        run_call(32'd11, 32'h5A, 1'b0, cyc, acc, n);
        check("rststr_next_call", acc, "Z");

        tick();
        syscall_req = 1'b1;
        sys_call_reg = 32'd10;
        tick();
        syscall_req = 1'b0;
        check("halt_set", {halted, stall}, {1'b1, 1'b1});
        repeat (5) tick();
        rxs = rxq.size();
        syscall_req = 1'b1;
        sys_call_reg = 32'd11;
        std_out_address = 32'h44;
        repeat (3) tick();
        syscall_req = 1'b0;
        check("halt_sticky", {halted, stall, char_valid, err_unsupported}, {1'b1, 1'b1, 1'b0, 1'b0});
        check("halt_no_bytes", 128'(rxq.size() - rxs), 128'(0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("halt_cleared", {halted, stall}, {1'b0, 1'b0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/syscall_unit.md
# syscall_unit

Execute-side system-call handler for the MIPS core. When a `syscall` instruction reaches execute, it consumes the register file's `$v0` (call code) and `$a0` (argument) outputs and stalls the pipeline. It then services the call: streaming a NUL-terminated string from data memory, printing a signed decimal integer, printing a character, or halting. Characters leave over a valid/ready byte stream to the console model.

## Interface
- `MAX_STR_LEN`, 256: maximum characters emitted per print_string; string is truncated at this count.
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous reset.
- `syscall_req`  in  1  level; high while a `syscall` occupies execute.
- `sys_call_reg`  in  32  `$v0` value from the register file.
- `std_out_address`  in  32  `$a0` value from the register file.
- `stall`  out  1  freeze PC/pipeline while high.
- `mem_addr`  out  32  byte address to data memory.
- `mem_rd`  out  1  byte read strobe.
- `mem_rdata`  in  8  byte read data, valid the cycle after `mem_rd`.
- `char_out`  out  8  ASCII byte.
- `char_valid`  out  1  `char_out` valid.
- `char_ready`  in  1  console accepts; transfer when `char_valid && char_ready` at posedge.
- `halted`  out  1  sticky; set by exit, cleared only by reset.
- `err_unsupported`  out  1  one-cycle pulse on unknown call code.

## Operation
- States: IDLE, STR_REQ, STR_CHK, INT_DIGIT, EMIT, DONE, HALT.
- IDLE: when `syscall_req` is high, latch `$v0` and `$a0` and decode:
  - 4 print_string: addr=`$a0`, count=0, go to STR_REQ.
  - 1 print_int: if `$a0[31]`, queue '-' in EMIT with magnitude = two's-complement negation (0x80000000 gives 2147483648 unsigned). Digit loop follows.
  - 11 print_char: `char_out=$a0[7:0]`, go to EMIT, then DONE.
  - 10 exit: go to HALT.
  - Any other code: pulse `err_unsupported`, go to DONE.
- STR_REQ: `mem_rd=1`, `mem_addr=addr`, then STR_CHK.
- STR_CHK: if `mem_rdata==0` or `count==MAX_STR_LEN`, go to DONE. Otherwise latch the byte, go to EMIT. After transfer, addr+1 (wraps 0xFFFFFFFF→0), count+1, back to STR_REQ.
- INT_DIGIT: power index p=9..0 over a 10^p constant table.
  - Each cycle: if mag ≥ 10^p, subtract and increment digit; else finish the digit.
  - Emit '0'+digit via EMIT if the digit is nonzero, a nonzero digit was already printed, or p==0. Then p−1.
  - After p=0 is emitted, go to DONE. Zero prints "0"; −2147483648 prints "-2147483648".
- EMIT: `char_valid=1`; `char_out` stays stable until transfer. No dropped or duplicated bytes.
- DONE: one cycle; `stall=0`; `syscall_req` ignored (prevents re-trigger while the instruction retires). Then IDLE.
- HALT: terminal; `stall=1`, `halted=1`; `syscall_req` ignored.
- `stall = syscall_req` (in IDLE) OR (state ∉ {IDLE, DONE}). It is combinational so the request cycle itself is frozen.

## Timing
- Reset values:
  - state=IDLE
  - `stall`=0 (unless `syscall_req` is high)
  - `mem_rd`=0, `mem_addr`=0
  - `char_out`=0, `char_valid`=0
  - `halted`=0, `err_unsupported`=0
- Reset mid-call aborts immediately. `char_valid` drops the cycle after, with no transfer completed. Memory read data in flight is discarded.
- print_string with `char_ready` tied high: 3 cycles per character, plus 2 for the NUL, plus 1 DONE.
- print_char: request cycle, 1 EMIT cycle, 1 DONE cycle.
- `char_ready` low stretches EMIT indefinitely; `stall` stays high throughout.
- `err_unsupported` is high exactly in the cycle after acceptance.

## Test plan
- Memory "Hi\0" at 0x100, `$v0`=4, `$a0`=0x100, ready high → bytes 0x48, 0x69 in order; `mem_rd` at 0x100, 0x101, 0x102; `stall` drops in DONE; 0 bytes if the string is empty.
- `$v0`=1, `$a0` = 0, 7, −305, 0x80000000 → "0", "7", "-305", "-2147483648"; no leading zeros.
- `$v0`=11, `$a0`=0x41 with `char_ready` low for 5 cycles → `char_out`=0x41 held stable; exactly one transfer.
- `syscall_req` held high through DONE → service runs exactly once.
- Unmapped memory with no NUL, MAX_STR_LEN=4 → exactly 4 bytes, then stop. Address wraps at 0xFFFFFFFE start.
- `$v0`=10 → `halted`=1 and `stall`=1 forever; reset clears both. Reset during a string → `char_valid`=0 next cycle; next syscall serviced normally.
- `$v0`=99 → `err_unsupported` single pulse, no output bytes.
